// File: rtl/cordic_rotator_iter_if.sv
// rtl/cordic_rotator_iter_if.sv - operand, result and step-table signals of the iterative CORDIC rotator
interface cordic_rotator_iter_if #(
   parameter int BIT_WIDTH   = 16,
   parameter int INPUT_WIDTH = 4
);
   logic                          in_valid;
   logic                          in_ready;
   logic signed [BIT_WIDTH-1:0]   x_in;
   logic signed [BIT_WIDTH-1:0]   y_in;
   logic signed [BIT_WIDTH-1:0]   z_in;
   logic                          out_valid;
   logic                          out_ready;
   logic signed [BIT_WIDTH-1:0]   x_out;
   logic signed [BIT_WIDTH-1:0]   y_out;
   logic signed [BIT_WIDTH-1:0]   z_out;
   logic        [INPUT_WIDTH-1:0] lut_index;
   logic signed [BIT_WIDTH-1:0]   lut_value;

   // Requester side: supplies operands, accepts results, serves the step table
   modport master (
      output in_valid, x_in, y_in, z_in, out_ready, lut_value,
      input  in_ready, out_valid, x_out, y_out, z_out, lut_index
   );

   // Engine side
   modport slave (
      input  in_valid, x_in, y_in, z_in, out_ready, lut_value,
      output in_ready, out_valid, x_out, y_out, z_out, lut_index
   );
endinterface

// File: rtl/cordic_rotator_iter.sv
// rtl/cordic_rotator_iter.sv - iterative rotation-mode CORDIC, one micro-rotation per clock
module cordic_rotator_iter #(
   parameter int BIT_WIDTH   = 16,
   parameter int ITERATIONS  = 16,
   parameter int INPUT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   cordic_rotator_iter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [INPUT_WIDTH-1:0] LAST_ITER = INPUT_WIDTH'(ITERATIONS - 1);

   state_t                        state;
   logic        [INPUT_WIDTH-1:0] counter;
   logic signed [BIT_WIDTH-1:0]   x_r;
   logic signed [BIT_WIDTH-1:0]   y_r;
   logic signed [BIT_WIDTH-1:0]   z_r;
   logic                          in_ready_r;
   logic                          out_valid_r;

   logic signed [BIT_WIDTH-1:0]   x_shift;
   logic signed [BIT_WIDTH-1:0]   y_shift;
   logic signed [BIT_WIDTH-1:0]   x_next;
   logic signed [BIT_WIDTH-1:0]   y_next;
   logic signed [BIT_WIDTH-1:0]   z_next;

   // One micro-rotation; the rotation direction follows the sign of the residual angle (zero rotates positive)
   always_comb begin
      x_shift = x_r >>> counter;
      y_shift = y_r >>> counter;
      x_next  = x_r;
      y_next  = y_r;
      z_next  = z_r;
      if (!z_r[BIT_WIDTH-1]) begin
         x_next = x_r - y_shift;
         y_next = y_r + x_shift;
         z_next = z_r - bus.lut_value;
      end else begin
         x_next = x_r + y_shift;
         y_next = y_r - x_shift;
         z_next = z_r + bus.lut_value;
      end
   end

   // Control FSM with datapath registers; handshake flags are registered alongside the state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         counter     <= '0;
         x_r         <= '0;
         y_r         <= '0;
         z_r         <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  x_r        <= bus.x_in;
                  y_r        <= bus.y_in;
                  z_r        <= bus.z_in;
                  counter    <= '0;
                  in_ready_r <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               x_r <= x_next;
               y_r <= y_next;
               z_r <= z_next;
               if (counter == LAST_ITER) begin
                  counter     <= '0;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.x_out     = x_r;
   assign bus.y_out     = y_r;
   assign bus.z_out     = z_r;
   // Step index is only meaningful while rotating; elsewhere it parks at 0
   assign bus.lut_index = (state == RUN) ? counter : '0;

endmodule
